fma_share_arbiter: RTL and testbench

Round-robin arbiter and issue sequencer that shares one fully pipelined 32x32+64 fused multiply-add unit (fixed latency, one issue per cycle, no stall) between two requesters. It registers the granted operands into the FMA, carries a requester tag alongside each operation through a matching delay line, and steers each result back to its owner with a one-cycle valid pulse. It sits between the requesting engines and the FMA instance; the FMA's own `rst` is tied to the same `rst`.

---
 rtl/fma_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_fma_share_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fma_share_arbiter.sv
// fma_share_arbiter
//   Round-robin arbiter and issue sequencer that shares one fully pipelined
//   32x32+64 multiply-add unit (fixed latency LAT, no stall) between two
//   requesters. Granted operands are registered into the FMA, a {valid, id}
//   tag travels alongside each operation, and each result is steered back
//   to its owner with a one-cycle valid pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   en                       issue enable (low blocks grants, flight drains)
//   req_valid0/1             requester has an operation
//   req_ready0/1             grant (handshake = valid & ready)
//   req_a0/1, req_b0/1       32-bit multiplicand / multiplier
//   req_c0/1                 64-bit addend
//   fma_a, fma_b, fma_c      registered FMA operands
//   fma_vld                  fma_* carry a real issue this cycle
//   fma_out                  FMA result (a*b+c, low 64 bits)
//   rsp_valid0/1             one-cycle result pulse per requester
//   rsp_data                 result, zero when no response is valid
//   idle                     nothing issued or in flight
//   issue_cnt                handshakes since reset, wrapping
module fma_share_arbiter #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_b1,
  input  logic [63:0]      req_c0,
  input  logic [63:0]      req_c1,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [63:0]      fma_c,
  output logic             fma_vld,
  input  logic [63:0]      fma_out,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [63:0]      rsp_data,
  output logic             idle,
  output logic [CNT_W-1:0] issue_cnt
);

  logic           ptr;
  logic           gnt0;
  logic           gnt1;
  logic           hs;
  logic           fma_id;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;

  // Grants are held low during reset so nothing can handshake while the
  // pipeline is being cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en && !rst) begin
      if (req_valid0 && req_valid1) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req_valid0;
        gnt1 = req_valid1;
      end
    end
  end

  assign req_ready0 = gnt0;
  assign req_ready1 = gnt1;
  assign hs         = gnt0 | gnt1;

  // After a grant the other requester gets priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (hs) begin
      ptr <= gnt0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fma_a   <= '0;
      fma_b   <= '0;
      fma_c   <= '0;
      fma_vld <= 1'b0;
      fma_id  <= 1'b0;
    end else begin
      fma_vld <= hs;
      fma_id  <= gnt1;
      if (gnt1) begin
        fma_a <= req_a1;
        fma_b <= req_b1;
        fma_c <= req_c1;
      end else if (gnt0) begin
        fma_a <= req_a0;
        fma_b <= req_b0;
        fma_c <= req_c0;
      end else begin
        fma_a <= '0;
        fma_b <= '0;
        fma_c <= '0;
      end
    end
  end

  // Tag line runs in lockstep with the FMA pipeline: loaded from the issue
  // register, so its last stage lines up with fma_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= fma_vld;
      tag_id[0] <= fma_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp_valid0 = tag_v[LAT-1] & ~tag_id[LAT-1];
  assign rsp_valid1 = tag_v[LAT-1] &  tag_id[LAT-1];
  assign rsp_data   = tag_v[LAT-1] ? fma_out : '0;
  assign idle       = ~fma_vld & ~(|tag_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if (hs) begin
      issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fma_share_arbiter.sv
// tb_fma_share_arbiter
//   Bench for fma_share_arbiter with a behavioural LAT-stage FMA attached.
//   A negedge monitor predicts grants from its own priority pointer, pushes
//   each expected result with its due cycle into a queue, and pops/compares
//   when the response is due.
module tb_fma_share_arbiter;

  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned MASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic          req_ready0, req_ready1;
  logic [31:0]   req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [63:0]   req_c0 = '0, req_c1 = '0;
  logic [31:0]   fma_a, fma_b;
  logic [63:0]   fma_c, fma_out, rsp_data;
  logic          fma_vld, rsp_valid0, rsp_valid1, idle;
  logic [CW-1:0] issue_cnt;

  fma_share_arbiter #(.LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_c0(req_c0), .req_c1(req_c1),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_vld(fma_vld),
    .fma_out(fma_out),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_data(rsp_data),
    .idle(idle), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FMA: operands sampled each edge, result LAT cycles later.
  logic [63:0] fpipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) fpipe[i] <= '0;
    end else begin
      fpipe[0] <= {32'b0, fma_a} * {32'b0, fma_b} + fma_c;
      for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
  end
  assign fma_out = fpipe[LAT-1];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_fma(input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] c);
    logic [127:0] full;
    full = 128'(a) * 128'(b) + 128'(c);
    return full[63:0];
  endfunction

  typedef struct packed {
    logic        id;
    logic [63:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        sb [$];
  int unsigned cyc = 0;
  logic        m_ptr = 1'b0;
  int unsigned m_cnt = 0;
  logic        p_vld = 1'b0;
  logic [31:0] p_a = '0, p_b = '0;
  logic [63:0] p_c = '0;

  always @(negedge clk) begin
    logic e0, e1;
    exp_t ex;
    if (rst) begin
      chk("rst_ready0", req_ready0, 0);
      chk("rst_ready1", req_ready1, 0);
      chk("rst_fma_vld", fma_vld, 0);
      chk("rst_fma_abc", {fma_a, fma_b} | fma_c, 0);
      chk("rst_rsp", {rsp_valid1, rsp_valid0}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_idle", idle, 1);
      chk("rst_issue_cnt", issue_cnt, 0);
      sb.delete();
      m_ptr = 1'b0; m_cnt = 0;
      p_vld = 1'b0; p_a = '0; p_b = '0; p_c = '0;
    end else begin
      e0 = 1'b0; e1 = 1'b0;
      if (en) begin
        if (req_valid0 && req_valid1) begin
          e0 = !m_ptr; e1 = m_ptr;
        end else begin
          e0 = req_valid0; e1 = req_valid1;
        end
      end
      chk("ready0", req_ready0, e0);
      chk("ready1", req_ready1, e1);
      chk("fma_vld", fma_vld, p_vld);
      chk("fma_a", fma_a, p_a);
      chk("fma_b", fma_b, p_b);
      chk("fma_c", fma_c, p_c);
      chk("idle", idle, sb.size() == 0);
      chk("issue_cnt", issue_cnt, m_cnt & MASK);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ex = sb.pop_front();
        chk("rsp_valid0", rsp_valid0, !ex.id);
        chk("rsp_valid1", rsp_valid1, ex.id);
        chk("rsp_data", rsp_data, ex.data);
      end else begin
        chk("rsp_valid0_quiet", rsp_valid0, 0);
        chk("rsp_valid1_quiet", rsp_valid1, 0);
        chk("rsp_data_quiet", rsp_data, 0);
      end
      p_vld = e0 | e1;
      p_a = e1 ? req_a1 : (e0 ? req_a0 : '0);
      p_b = e1 ? req_b1 : (e0 ? req_b0 : '0);
      p_c = e1 ? req_c1 : (e0 ? req_c0 : '0);
      if (e0 | e1) begin
        ex.id   = e1;
        ex.data = ref_fma(p_a, p_b, p_c);
        ex.due  = cyc + 1 + LAT;
        sb.push_back(ex);
        m_ptr = e0;
        m_cnt = m_cnt + 1;
      end
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] c);
    req_valid0 = v; req_a0 = a; req_b0 = b; req_c0 = c;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] c);
    req_valid1 = v; req_a1 = a; req_b1 = b; req_c1 = c;
  endtask

  initial begin
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;
    en  = 1'b1;
    step(1);

    // Single requester: 255*32+1 = 8161
    set0(1, 255, 32, 1);
    step(1);
    set0(0, 0, 0, 0);
    step(LAT + 4);

    // Contention: alternating grants, 386 and 1379
    set0(1, 12, 32, 2);
    set1(1, 43, 32, 3);
    step(4);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(LAT + 4);

    // Back-to-back single source, a=b=c=i
    for (int i = 1; i <= 8; i++) begin
      set1(1, 32'(i), 32'(i), 64'(i));
      step(1);
    end
    set1(0, 0, 0, 0);
    step(LAT + 4);

    // Overflow: low 64 bits of (2^32-1)^2 + 2^64-1
    set0(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    set0(0, 0, 0, 0);
    step(LAT + 3);

    // Enable gating with two operations in flight
    set0(1, 7, 9, 5);
    set1(1, 11, 13, 17);
    step(2);
    en = 1'b0;
    step(3);
    en = 1'b1;
    step(2);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(LAT + 4);

    // Reset with three operations in flight; valids stay high during reset
    set0(1, 100, 200, 300);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set0(0, 0, 0, 0);
    step(LAT + 3);

    // Counter wrap: 18 consecutive handshakes on a 4-bit counter
    for (int i = 0; i < 18; i++) begin
      set0(1, 32'(i * 3), 32'(i + 5), 64'(i));
      step(1);
    end
    set0(0, 0, 0, 0);
    step(LAT + 3);

    // Random interleaving with occasional enable drops
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 7) != 0);
      set0($urandom_range(0, 1) == 1, $urandom, $urandom, {$urandom, $urandom});
      set1($urandom_range(0, 1) == 1, $urandom, $urandom, {$urandom, $urandom});
      step(1);
    end
    en = 1'b1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(LAT + 4);

    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
